// File: rtl/fb_pkg.sv
// Shared framebuffer constants, fill state encoding and a constant row-offset helper.
// Used by both the fill engine (write side) and the framebuffer read side.
// Pure declarations; no logic of its own.
package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int ADDR_W    = 19;
    localparam int COLOR_W   = 24;
    localparam int COORD_W   = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        FILL   = 2'd2,
        FINISH = 2'd3
    } fill_state_e;

    // y * width built as a shift-add over the set bits of the constant width,
    // so only a fixed adder tree is produced, never a general multiplier.
    function automatic logic [ADDR_W-1:0] row_offset(input logic [COORD_W-1:0] y,
                                                     input int unsigned       width);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (width[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/rect_clip.sv
// Clips a requested rectangle to the framebuffer and flags an empty area.
// Latency: purely combinational.
// Backpressure: none; outputs follow the inputs.
module rect_clip
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
    input  logic [COORD_W-1:0] X0,
    input  logic [COORD_W-1:0] Y0,
    input  logic [COORD_W-1:0] W,
    input  logic [COORD_W-1:0] H,
    input  logic               CLEAR,
    output logic [COORD_W-1:0] x_start,
    output logic [COORD_W-1:0] y_start,
    output logic [COORD_W:0]   x_end,
    output logic [COORD_W:0]   y_end,
    output logic               empty
);

    // One extra bit so X0+W and Y0+H can never wrap.
    localparam int SUM_W = COORD_W + 1;
    localparam logic [SUM_W-1:0] FB_W_S = SUM_W'(FB_WIDTH);
    localparam logic [SUM_W-1:0] FB_H_S = SUM_W'(FB_HEIGHT);

    logic [SUM_W-1:0] sum_x;
    logic [SUM_W-1:0] sum_y;

    // Clip the far edges to the frame; CLEAR overrides the request with the full frame.
    always_comb begin
        sum_x   = SUM_W'(X0) + SUM_W'(W);
        sum_y   = SUM_W'(Y0) + SUM_W'(H);
        x_start = X0;
        y_start = Y0;
        x_end   = (sum_x > FB_W_S) ? FB_W_S : sum_x;
        y_end   = (sum_y > FB_H_S) ? FB_H_S : sum_y;
        empty   = (SUM_W'(X0) >= FB_W_S) || (SUM_W'(Y0) >= FB_H_S) ||
                  (W == '0) || (H == '0);
        if (CLEAR) begin
            x_start = '0;
            y_start = '0;
            x_end   = FB_W_S;
            y_end   = FB_H_S;
            empty   = 1'b0;
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Fills a clipped rectangle (or the whole frame) with one colour, one pixel write per cycle.
// Latency: first write two cycles after START is accepted; DONE one cycle after the last write.
// Backpressure: none; START is ignored while a fill is in progress, the RAM accepts every write.
module rect_fill_engine
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               CLEAR,
    input  logic [COORD_W-1:0] X0,
    input  logic [COORD_W-1:0] Y0,
    input  logic [COORD_W-1:0] W,
    input  logic [COORD_W-1:0] H,
    input  logic [COLOR_W-1:0] COLOR,
    output logic               BUSY,
    output logic               DONE,
    output logic               WRITE_EN,
    output logic [ADDR_W-1:0]  WRITE_ADDR,
    output logic [COLOR_W-1:0] WRITE_DATA
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

    fill_state_e state_q, state_d;

    // Request captured at acceptance so later input changes cannot disturb the fill.
    logic [COORD_W-1:0] x0_q, x0_d;
    logic [COORD_W-1:0] y0_q, y0_d;
    logic [COORD_W-1:0] w_q, w_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               clear_q, clear_d;

    // Raster position, base address of the current row, and the write port registers.
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [ADDR_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COLOR_W-1:0] data_q, data_d;

    logic [COORD_W-1:0] x_start;
    logic [COORD_W-1:0] y_start;
    logic [COORD_W:0]   x_end;
    logic [COORD_W:0]   y_end;
    logic               empty;
    logic               last_col;
    logic               last_row;
    logic [ADDR_W-1:0]  first_row;

    rect_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_clip (
        .X0      (x0_q),
        .Y0      (y0_q),
        .W       (w_q),
        .H       (h_q),
        .CLEAR   (clear_q),
        .x_start (x_start),
        .y_start (y_start),
        .x_end   (x_end),
        .y_end   (y_end),
        .empty   (empty)
    );

    assign last_col   = ({1'b0, x_q} == (x_end - (COORD_W+1)'(1)));
    assign last_row   = ({1'b0, y_q} == (y_end - (COORD_W+1)'(1)));
    assign first_row  = row_offset(y_start, FB_WIDTH);
    assign WRITE_ADDR = addr_q;
    assign WRITE_DATA = data_q;

    // Next-state, datapath update and status outputs; everything holds unless a state acts.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        clear_d  = clear_q;
        x_d      = x_q;
        y_d      = y_q;
        row_d    = row_q;
        addr_d   = addr_q;
        data_d   = data_q;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        WRITE_EN = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    x0_d    = X0;
                    y0_d    = Y0;
                    w_d     = W;
                    h_d     = H;
                    color_d = COLOR;
                    clear_d = CLEAR;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                BUSY = 1'b1;
                if (empty) begin
                    state_d = FINISH;
                end else begin
                    x_d     = x_start;
                    y_d     = y_start;
                    row_d   = first_row;
                    addr_d  = first_row + ADDR_W'(x_start);
                    data_d  = color_q;
                    state_d = FILL;
                end
            end
            FILL: begin
                BUSY     = 1'b1;
                WRITE_EN = 1'b1;
                // On the final pixel the address stays put so the held value is the last write.
                if (last_col) begin
                    if (last_row) begin
                        state_d = FINISH;
                    end else begin
                        x_d    = x_start;
                        y_d    = y_q + COORD_W'(1);
                        row_d  = row_q + ROW_STEP;
                        addr_d = row_q + ROW_STEP + ADDR_W'(x_start);
                    end
                end else begin
                    x_d    = x_q + COORD_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            FINISH: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any request in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            clear_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            clear_q <= clear_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: a reference model turns each accepted request into
// a list of expected pixel writes and a DONE cycle; a monitor compares every DUT cycle.
// A reduced frame height keeps the full-frame CLEAR run short.
module tb_rect_fill_engine;

    localparam int FBW = 640;
    localparam int FBH = 48;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic        CLEAR;
    logic [9:0]  X0;
    logic [9:0]  Y0;
    logic [9:0]  W;
    logic [9:0]  H;
    logic [23:0] COLOR;
    logic        BUSY;
    logic        DONE;
    logic        WRITE_EN;
    logic [18:0] WRITE_ADDR;
    logic [23:0] WRITE_DATA;

    rect_fill_engine #(
        .FB_WIDTH  (FBW),
        .FB_HEIGHT (FBH)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .CLEAR      (CLEAR),
        .X0         (X0),
        .Y0         (Y0),
        .W          (W),
        .H          (H),
        .COLOR      (COLOR),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .WRITE_EN   (WRITE_EN),
        .WRITE_ADDR (WRITE_ADDR),
        .WRITE_DATA (WRITE_DATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_wr_t;

    exp_wr_t wq[$];
    int      dq[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int last_addr = 0;
    int last_data = 0;
    int busy_lo = -1;
    int busy_hi = -1;
    int rst_clear_cyc = -1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Monitor: samples on the falling edge and pops the scoreboard queues.
    initial begin
        exp_wr_t e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (cyc == rst_clear_cyc) begin
                    last_addr = 0;
                    last_data = 0;
                end
                if (WRITE_EN) begin
                    if (wq.size() == 0) begin
                        check("wr_unexpected", WRITE_EN, 0);
                    end else begin
                        e = wq.pop_front();
                        check("wr_addr", WRITE_ADDR, e.addr);
                        check("wr_data", WRITE_DATA, e.data);
                        check("wr_cycle", cyc, e.cyc);
                        last_addr = e.addr;
                        last_data = e.data;
                    end
                end else begin
                    if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                        check("wr_missing", WRITE_EN, 1);
                        void'(wq.pop_front());
                    end
                    check("hold_addr", WRITE_ADDR, last_addr);
                    check("hold_data", WRITE_DATA, last_data);
                end
                if (DONE) begin
                    if (dq.size() == 0) check("done_unexpected", DONE, 0);
                    else check("done_cycle", cyc, dq.pop_front());
                end else if (dq.size() > 0 && dq[0] <= cyc) begin
                    check("done_missing", DONE, 1);
                    void'(dq.pop_front());
                end
                check("busy", BUSY, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
                check("addr_range", (WRITE_ADDR < FBW * FBH) ? 1 : 0, 1);
            end
        end
    end

    // Issue one request while idle; the model enumerates the clipped pixels in raster order.
    // pulses: also pulse START while busy. rst_at: assert RESET during that write number.
    task automatic issue(input bit clr, input int x0, input int y0, input int w, input int h,
                         input int col, input bit pulses, input int rst_at);
        int t, xs, ys, xe, ye, k, done;
        bit empty;
        exp_wr_t e;
        t     = cyc;
        START = 1'b1;
        CLEAR = clr;
        X0    = 10'(x0);
        Y0    = 10'(y0);
        W     = 10'(w);
        H     = 10'(h);
        COLOR = 24'(col);
        if (clr) begin
            xs = 0; ys = 0; xe = FBW; ye = FBH; empty = 1'b0;
        end else begin
            xs    = x0;
            ys    = y0;
            xe    = (x0 + w < FBW) ? x0 + w : FBW;
            ye    = (y0 + h < FBH) ? y0 + h : FBH;
            empty = (x0 >= FBW) || (y0 >= FBH) || (w == 0) || (h == 0);
        end
        k = 0;
        if (!empty) begin
            for (int y = ys; y < ye; y++) begin
                for (int x = xs; x < xe; x++) begin
                    e.addr = y * FBW + x;
                    e.data = col & 24'hFFFFFF;
                    e.cyc  = t + 2 + k;
                    wq.push_back(e);
                    k++;
                end
            end
        end
        done = t + 2 + k;
        dq.push_back(done);
        busy_lo = t + 1;
        busy_hi = done - 1;
        while (cyc < done + 1) begin
            step();
            START = pulses && (cyc <= done) && ($urandom_range(0, 3) == 0);
            CLEAR = 1'($urandom_range(0, 1));
            X0    = 10'($urandom_range(0, 1023));
            Y0    = 10'($urandom_range(0, 1023));
            W     = 10'($urandom_range(0, 1023));
            H     = 10'($urandom_range(0, 1023));
            COLOR = 24'($urandom);
            if (rst_at > 0 && cyc == t + 1 + rst_at) begin
                RESET = 1'b1;
                START = 1'b1;
                while (wq.size() > 0 && wq[wq.size()-1].cyc > cyc) void'(wq.pop_back());
                dq.delete();
                busy_hi       = cyc;
                rst_clear_cyc = cyc + 1;
                done          = cyc;
            end
        end
        START = 1'b0;
        if (rst_at > 0) begin
            check("abort_we", WRITE_EN, 0);
            check("abort_busy", BUSY, 0);
            check("abort_done", DONE, 0);
            check("abort_addr", WRITE_ADDR, 0);
            RESET = 1'b0;
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    // Stimulus: reset checks, directed boundary cases, then randomized rectangles.
    initial begin
        int x0, y0, w, h;
        RESET = 1'b1;
        START = 1'b0;
        CLEAR = 1'b0;
        X0 = '0; Y0 = '0; W = '0; H = '0; COLOR = '0;
        repeat (3) step();
        START = 1'b1;
        step();
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_we", WRITE_EN, 0);
        check("rst_addr", WRITE_ADDR, 0);
        check("rst_data", WRITE_DATA, 0);
        START  = 1'b0;
        RESET  = 1'b0;
        mon_en = 1'b1;
        step();

        issue(0, 5, 2, 1, 1, 24'h000003, 0, 0);
        issue(0, 10, 0, 3, 2, 24'hA5A5A5, 1, 0);
        issue(0, 638, FBH - 1, 5, 5, 24'h00FF00, 1, 0);
        issue(0, 5, 5, 0, 4, 24'h111111, 1, 0);
        issue(0, 700, 3, 4, 4, 24'h222222, 1, 0);
        issue(0, 3, FBH, 4, 4, 24'h333333, 1, 0);
        issue(0, 7, 7, 4, 0, 24'h444444, 1, 0);
        issue(1, 300, 20, 5, 5, 24'hC0FFEE, 1, 0);
        repeat (4) step();
        issue(0, 10, 0, 3, 2, 24'h123456, 0, 3);
        issue(0, 1, 1, 2, 2, 24'h654321, 1, 0);

        for (int i = 0; i < 30; i++) begin
            x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(600, 700) : $urandom_range(0, 639);
            y0 = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 55) : $urandom_range(0, FBH - 1);
            if ($urandom_range(0, 5) == 0) begin
                w = $urandom_range(600, 1023);
                h = $urandom_range(1, 2);
            end else begin
                w = $urandom_range(0, 16);
                h = $urandom_range(0, 6);
            end
            issue(0, x0, y0, w, h, $urandom, 1'($urandom_range(0, 1)), 0);
        end

        repeat (5) step();
        check("wq_drained", wq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 640: framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 480: framebuffer height in pixels.
REQ-003 SHALL have port CLK  input  1  single clock; it also drives the framebuffer WRITE_CLK.
REQ-004 SHALL have port RESET  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port START  input  1  request to fill one rectangle, sampled on the rising edge of CLK.
REQ-006 SHALL have port CLEAR  input  1  qualifies START: fill the whole frame and ignore X0/Y0/W/H.
REQ-007 SHALL have ports X0, Y0  input  10 each  top-left corner of the rectangle, in pixels.
REQ-008 SHALL have ports W, H  input  10 each  rectangle width and height, in pixels.
REQ-009 SHALL have port COLOR  input  24  pixel value to write.
REQ-010 SHALL have port BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse when the fill completes.
REQ-012 SHALL have port WRITE_EN  output  1  high on every cycle in which a valid pixel write is presented.
REQ-013 SHALL have port WRITE_ADDR  output  19  linear pixel address, y*FB_WIDTH+x.
REQ-014 SHALL have port WRITE_DATA  output  24  pixel value, equal to the captured COLOR.

Function
REQ-015 SHALL implement the states IDLE, SETUP, FILL and FINISH.
- IDLE -> SETUP on START.
- SETUP -> FILL, or -> FINISH if the clipped area is empty.
- FILL -> FINISH after the last pixel.
- FINISH -> IDLE.
REQ-016 SHALL capture X0, Y0, W, H, COLOR and CLEAR in the cycle START is accepted in IDLE; later input changes SHALL have no effect on the fill in progress.
REQ-017 SHALL ignore START while not in IDLE; there is no queueing.
REQ-018 SHALL, in SETUP, clip the rectangle as follows:
- x_end = min(X0+W, FB_WIDTH); y_end = min(Y0+H, FB_HEIGHT).
- The area is empty if X0 >= FB_WIDTH, Y0 >= FB_HEIGHT, W = 0 or H = 0.
- CLEAR forces the area to 0,0,FB_WIDTH,FB_HEIGHT.
- Clip sums SHALL be 11 bits wide so they cannot wrap.
REQ-019 SHALL, in FILL, write one pixel per cycle in raster order: x increments; at x_end-1, x reloads to X0 and y increments; the last pixel is (x_end-1, y_end-1).
REQ-020 SHALL form WRITE_ADDR incrementally without a multiplier: row base += FB_WIDTH at each row change; WRITE_ADDR = row base + x.
REQ-021 SHALL meet this timing: START accepted at edge t; SETUP during cycle t+1; first WRITE_EN at cycle t+2; an N-pixel fill has WRITE_EN high for exactly N consecutive cycles; DONE high in the cycle after the last write.
REQ-022 SHALL, for an empty area, produce no WRITE_EN and assert DONE at cycle t+2.
REQ-023 SHALL assert BUSY from cycle t+1 through the last FILL cycle; BUSY SHALL be low in the DONE cycle, and START is accepted again in the DONE cycle+1.
REQ-024 SHALL hold WRITE_ADDR and WRITE_DATA at their last written values when WRITE_EN is low, because the downstream RAM write-enable is tied high and re-writing the last pixel must be harmless.
REQ-025 SHALL NOT drive WRITE_ADDR to FB_WIDTH*FB_HEIGHT or above.

Reset
REQ-026 SHALL, on RESET, go to IDLE with BUSY=0, DONE=0, WRITE_EN=0, WRITE_ADDR=0, WRITE_DATA=0.
REQ-027 SHALL abort any fill in progress when RESET occurs mid-fill, with no DONE pulse; the partially written frame is acceptable.
REQ-028 SHALL give RESET priority over START in the same cycle.

Structure
REQ-029 SHALL take FB_WIDTH, FB_HEIGHT, ADDR_W=19, COLOR_W=24 and the state enum from shared package fb_pkg; the framebuffer read side uses the same constants.
REQ-030 SHALL place the clipping arithmetic in combinational sub-module rect_clip (inputs X0/Y0/W/H/CLEAR; outputs x_start, y_start, x_end, y_end, empty).

Verification
REQ-031 Single-pixel fill: START, X0=5, Y0=2, W=1, H=1, COLOR=0x000003 -> one write at addr 1285, data 0x000003, at t+2; DONE at t+3.
REQ-032 Rectangle fill: X0=10, Y0=0, W=3, H=2 -> six consecutive writes at addrs 10,11,12,650,651,652; DONE in the following cycle.
REQ-033 Right-edge clipping: X0=638, Y0=479, W=5, H=5 -> exactly two writes at 307198 and 307199; no address >= 307200.
REQ-034 Empty area: W=0, then X0=700 -> zero WRITE_EN in each case; DONE at t+2 in each case; START pulsed while BUSY is ignored, so only one DONE per accepted START.
REQ-035 CLEAR: CLEAR=1 with START -> 307200 consecutive writes, addr 0..307199; WRITE_ADDR then holds 307199 while idle.
REQ-036 Reset mid-fill: RESET asserted during write 3 of 6 -> next cycle WRITE_EN=0, BUSY=0, WRITE_ADDR=0; no DONE; a new START then behaves normally.
